distributor14_32: RTL and testbench
===================================

Name: distributor14_32

Overview:
- 1-to-4 routing buffer that delivers a 32-bit word to one of four consumer channels, selected by a 2-bit destination field.
- It is the fan-out counterpart of the 4-to-1 operand selectors in the pipeline CPU. Writeback/forwarding results from one producer are steered to four downstream consumers (e.g. regfile port, HI/LO, CP0, debug), each with its own valid/ready handshake.
- Each channel has a small FIFO, so a stalled consumer does not block traffic to the other channels.

Parameters:
- DATA_W, 32, data word width in bits
- DEPTH, 2, entries per channel FIFO (power of two, >= 2)
- CNT_W, 16, width of per-channel statistics counters (used only with the optional feature)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer holds a valid word
- in_ready  output  1  addressed channel can accept this cycle
- in_data  input  DATA_W  word to route
- in_dest  input  2  destination channel 0..3
- out_valid  output  4  bit i: channel i FIFO non-empty
- out_ready  input  4  bit i: consumer i takes head word this cycle
- out_data  output  4*DATA_W  channel i head word at bits [i*DATA_W +: DATA_W]
- stat_cnt  output  4*CNT_W  per-channel accepted-word counts (only with DISTRIB_STATS_EN)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset (sampled high at a clk edge):
  - all FIFOs emptied: pointers and counts set to 0
  - out_valid = 4'b0000, out_data = 0
  - stat_cnt = 0 when the feature is present
  - reset mid-transfer discards all buffered words; no partial output
- in_ready is combinational: in_ready = (count[in_dest] != DEPTH).
  - It depends only on current occupancy, never on out_ready. There is no full-pass-through path.
- Accept: in_valid & in_ready at a clk edge pushes in_data into FIFO[in_dest].
  - Latency: the word is visible at out_data/out_valid of that channel in the next cycle.
  - No combinational in->out bypass.
- Pop: out_valid[i] & out_ready[i] at a clk edge advances channel i head.
  - out_ready[i] while out_valid[i]=0 is ignored.
- Simultaneous push and pop on the same channel: count is unchanged, both pointers advance.
  - When count==DEPTH, the push is refused that cycle (in_ready=0) even if a pop occurs.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Ordering: per-channel FIFO order is preserved. Channels are independent, with no ordering across channels.
- out_data[i] holds the head entry. When out_valid[i]=0 it holds the last value (do-not-care for checkers).
- in_valid low: in_dest/in_data are ignored and in_ready still reflects the addressed channel.
- Each channel has a per-channel state machine, derived from count:
  - EMPTY: count==0
  - PARTIAL: 0<count<DEPTH
  - FULL: count==DEPTH
  - transitions by push/pop as above; push-only moves toward FULL, pop-only toward EMPTY, both stay put.

Optional Feature:
- DISTRIB_STATS_EN defined:
  - stat_cnt port exists
  - each channel has a CNT_W-bit counter, +1 on every accepted push to that channel
  - counter saturates at all-ones, no wrap
  - cleared by reset only
- Undefined: the stat_cnt port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - NUM_CH=4, DEST_W=2, default DATA_W=32
  - channel index constants CH_REGF=0, CH_HILO=1, CH_CP0=2, CH_DBG=3
- One sub-module: distrib_fifo (DATA_W, DEPTH; push/pop/full/empty/head, synchronous reset), instantiated 4 times by generate.
- Top contains demux of the push enable, in_ready mux, and optional stats.

Test Plan:
- Reset, then in_valid=1, in_dest=2, in_data=32'hDEADBEEF, out_ready=0 → in_ready=1; next cycle out_valid=4'b0100, out_data[95:64]=32'hDEADBEEF.
- Fill channel 1 with 32'h11, 32'h22 (out_ready=0), then present a third word to dest 1 → in_ready=0; present a word to dest 3 → accepted, out_valid=4'b1010.
- Channel 1 full with a push offered and out_ready[1]=1 → pop of 32'h11 that cycle, push refused; next cycle in_ready=1, head=32'h22.
- Channel 0 holding 1 word, simultaneous push 32'hA5 and pop → count stays 1, head becomes 32'hA5; 10 back-to-back push/pop cycles verify pointer wrap and order.
- Assert reset with 2 words in channels 0 and 3 → next cycle out_valid=0 and all in_ready=1; a subsequent word routes normally.
- With DISTRIB_STATS_EN, CNT_W=4: push 20 words to channel 2 → stat_cnt[11:8]=4'hF (saturated), other channels 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline CPU definitions: channel count, destination width and the
// per-channel occupancy states used by the writeback distributor.
package cpu_pkg;

   localparam int NUM_CH     = 4;
   localparam int DEST_W     = 2;
   localparam int DEF_DATA_W = 32;

   localparam logic [DEST_W-1:0] CH_REGF = 2'd0;
   localparam logic [DEST_W-1:0] CH_HILO = 2'd1;
   localparam logic [DEST_W-1:0] CH_CP0  = 2'd2;
   localparam logic [DEST_W-1:0] CH_DBG  = 2'd3;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } ch_state_e;

endpackage

// File: rtl/distrib_fifo.sv
// Per-channel FIFO for the distributor. The occupancy state machine
// (EMPTY/PARTIAL/FULL) advances together with the count register.
module distrib_fifo
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] LIM = DEPTH[PTR_W:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   ch_state_e         state;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && (state != ST_FULL);
   assign do_pop  = pop  && (state != ST_EMPTY);

   // Storage is cleared on reset so the head reads as zero afterwards;
   // pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         state  <= ST_EMPTY;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10: begin
               count <= count + 1'b1;
               state <= (count == LIM - 1'b1) ? ST_FULL : ST_PARTIAL;
            end
            2'b01: begin
               count <= count - 1'b1;
               state <= (count == {{PTR_W{1'b0}}, 1'b1}) ? ST_EMPTY : ST_PARTIAL;
            end
            default: begin
            end
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (state == ST_FULL);
   assign empty = (state == ST_EMPTY);

endmodule

// File: rtl/distributor14_32.sv
// 1-to-4 writeback distributor: routes a word to one of four buffered
// consumer channels. Define DISTRIB_STATS_EN to add per-channel push counters.
module distributor14_32
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 2
`ifdef DISTRIB_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [DEST_W-1:0]        in_dest,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data
`ifdef DISTRIB_STATS_EN
   ,
   output logic [NUM_CH*CNT_W-1:0]  stat_cnt
`endif
);

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] push;

   // Readiness depends only on the addressed channel's occupancy, never on out_ready.
   assign in_ready = ~full[in_dest];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign push[i]      = in_valid && !full[i] && (in_dest == DEST_W'(i));
      assign out_valid[i] = ~empty[i];

      distrib_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .push    (push[i]),
         .pop     (out_ready[i]),
         .wr_data (in_data),
         .head    (out_data[i*DATA_W +: DATA_W]),
         .full    (full[i]),
         .empty   (empty[i])
      );

`ifdef DISTRIB_STATS_EN
      logic [CNT_W-1:0] stat_q;

      // Saturating count of accepted words.
      always_ff @(posedge clk) begin
         if (reset) begin
            stat_q <= '0;
         end else if (push[i] && (stat_q != {CNT_W{1'b1}})) begin
            stat_q <= stat_q + 1'b1;
         end
      end

      assign stat_cnt[i*CNT_W +: CNT_W] = stat_q;
`endif
   end

endmodule

// File: tb/tb_distributor14_32.sv
// Scoreboard bench for distributor14_32: the driver queues expected words per
// channel, a negedge monitor checks every word the DUT hands to a consumer.
module tb_distributor14_32;
   import cpu_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int CW    = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [DW-1:0]        in_data;
   logic [DEST_W-1:0]    in_dest;
   logic [NUM_CH-1:0]    out_valid;
   logic [NUM_CH-1:0]    out_ready;
   logic [NUM_CH*DW-1:0] out_data;
`ifdef DISTRIB_STATS_EN
   logic [NUM_CH*CW-1:0] stat_cnt;
`endif

   logic [DW-1:0] exp_q [NUM_CH][$];
   int total = 0;
   int bad   = 0;

   distributor14_32 #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
`ifdef DISTRIB_STATS_EN
      ,
      .CNT_W  (CW)
`endif
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DISTRIB_STATS_EN
      ,
      .stat_cnt  (stat_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Drive one cycle of inputs, check in_ready against the model occupancy,
   // and queue the word if it is expected to be accepted.
   task automatic apply_stimulus(input logic v, input logic [DEST_W-1:0] d,
                                 input logic [DW-1:0] data, input logic [NUM_CH-1:0] rdy);
      logic exp_rdy;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_dest   = d;
      in_data   = data;
      out_ready = rdy;
      #1;
      exp_rdy = (exp_q[d].size() < DEPTH);
      check_output("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      if (v && exp_rdy) exp_q[d].push_back(data);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
   endtask

   // Monitor: consume expected words whenever the DUT completes a handshake.
   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_word ch%0d: got %0h want none", i, out_data[i*DW +: DW]);
               end else begin
                  check_output($sformatf("data_ch%0d", i), {32'd0, out_data[i*DW +: DW]}, {32'd0, exp_q[i].pop_front()});
               end
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_dest   = '0;
      out_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_output("reset_valid", {60'd0, out_valid}, 64'd0);
      check_output("reset_data_lo", out_data[63:0], 64'd0);
      check_output("reset_data_hi", out_data[127:64], 64'd0);
      check_output("reset_ready", {63'd0, in_ready}, 64'd1);

      // Single word to CP0 channel
      apply_stimulus(1'b1, CH_CP0, 32'hDEADBEEF, 4'b0000);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("ov_single", {60'd0, out_valid}, 64'h4);
      check_output("head_cp0", {32'd0, out_data[95:64]}, 64'hDEADBEEF);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0100);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("ov_drained", {60'd0, out_valid}, 64'h0);

      // Fill HILO, refuse a third word, other channel still accepts
      apply_stimulus(1'b1, CH_HILO, 32'h11, 4'b0000);
      apply_stimulus(1'b1, CH_HILO, 32'h22, 4'b0000);
      apply_stimulus(1'b1, CH_HILO, 32'h33, 4'b0000);
      apply_stimulus(1'b1, CH_DBG, 32'h44, 4'b0000);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("ov_1010", {60'd0, out_valid}, 64'hA);

      // Full channel: pop happens, push refused the same cycle
      apply_stimulus(1'b1, CH_HILO, 32'h55, 4'b0010);
      apply_stimulus(1'b0, CH_HILO, 32'h0, 4'b0000);
      check_output("head_hilo", {32'd0, out_data[63:32]}, 64'h22);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b1010);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("ov_empty2", {60'd0, out_valid}, 64'h0);

      // Simultaneous push/pop on REGF, then back-to-back wrap
      apply_stimulus(1'b1, CH_REGF, 32'h77, 4'b0000);
      apply_stimulus(1'b1, CH_REGF, 32'hA5, 4'b0001);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("ov_regf", {60'd0, out_valid}, 64'h1);
      check_output("head_regf", {32'd0, out_data[31:0]}, 64'hA5);
      for (int k = 0; k < 10; k++) begin
         apply_stimulus(1'b1, CH_REGF, 32'h100 + k, 4'b0001);
      end
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("head_wrap", {32'd0, out_data[31:0]}, 64'h109);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0001);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("ov_empty3", {60'd0, out_valid}, 64'h0);

      // Reset with buffered words discards them
      apply_stimulus(1'b1, CH_REGF, 32'hC1, 4'b0000);
      apply_stimulus(1'b1, CH_REGF, 32'hC2, 4'b0000);
      apply_stimulus(1'b1, CH_DBG, 32'hD1, 4'b0000);
      apply_stimulus(1'b1, CH_DBG, 32'hD2, 4'b0000);
      do_reset();
      #1;
      check_output("ov_after_rst", {60'd0, out_valid}, 64'h0);
      for (int d = 0; d < NUM_CH; d++) begin
         in_dest = DEST_W'(d);
         #1;
         check_output($sformatf("ready_rst_ch%0d", d), {63'd0, in_ready}, 64'd1);
      end
      apply_stimulus(1'b1, CH_DBG, 32'hE0, 4'b0000);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("ov_post_rst", {60'd0, out_valid}, 64'h8);
      check_output("head_dbg", {32'd0, out_data[127:96]}, 64'hE0);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b1000);

`ifdef DISTRIB_STATS_EN
      do_reset();
      #1;
      check_output("stat_rst", {48'd0, stat_cnt}, 64'h0);
      for (int k = 0; k < 20; k++) begin
         apply_stimulus(1'b1, CH_CP0, 32'h200 + k, 4'b0100);
      end
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0100);
      apply_stimulus(1'b0, CH_REGF, 32'h0, 4'b0000);
      check_output("stat_sat", {48'd0, stat_cnt}, 64'h0F00);
`endif

      repeat (2) @(posedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
         check_output($sformatf("leftover_ch%0d", i), 64'(exp_q[i].size()), 64'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
